// File: rtl/regfile_pcstack.sv
// Register file with GPO/GPI/zero/PC index map, same-cycle write bypass and a
// circular call/return stack with sticky overflow/underflow flags.
module regfile_pcstack #(
    parameter int W           = 8,
    parameter int NREGS       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          d_we,
    input  logic [AW-1:0] d_op,
    input  logic [W-1:0]  in,
    input  logic [W-1:0]  pc_in,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] rx_op,
    input  logic [AW-1:0] ry_op,
    input  logic [W-1:0]  gpi,
    output logic [W-1:0]  gpo,
    output logic [W-1:0]  pc_out,
    output logic [W-1:0]  rx_out,
    output logic [W-1:0]  ry_out,
    output logic          stack_ovf,
    output logic          stack_unf
);

    localparam int NGEN = NREGS - 3;
    localparam int SPW  = $clog2(STACK_DEPTH);
    localparam int DW   = $clog2(STACK_DEPTH + 1);

    localparam logic [AW-1:0] GPO_IDX  = AW'(NREGS - 4);
    localparam logic [AW-1:0] GPI_IDX  = AW'(NREGS - 3);
    localparam logic [AW-1:0] ZERO_IDX = AW'(NREGS - 2);
    localparam logic [AW-1:0] PC_IDX   = AW'(NREGS - 1);

    logic [W-1:0]   regs [NGEN];
    logic [W-1:0]   gpi_meta;
    logic [W-1:0]   gpi_sync;
    logic [W-1:0]   pc;
    logic [W-1:0]   stack [STACK_DEPTH];
    logic [SPW-1:0] top;
    logic [DW-1:0]  depth;
    logic           ovf;
    logic           unf;

    logic           wr_en;
    logic           gen_wr;
    logic           full;
    logic           empty;
    logic [SPW-1:0] top_inc;
    logic [SPW-1:0] top_dec;
    logic [W-1:0]   pc_next;
    logic           push;
    logic           pop;
    logic           set_unf;

    logic [AW-1:0]  sel [2];
    logic [W-1:0]   rd  [2];

    assign wr_en   = !stall && d_we;
    assign gen_wr  = wr_en && (d_op <= GPO_IDX);
    assign full    = (depth == DW'(STACK_DEPTH));
    assign empty   = (depth == '0);

    // top is the next free slot; the newest entry lives just below it
    assign top_inc = (top == SPW'(STACK_DEPTH - 1)) ? '0 : top + SPW'(1);
    assign top_dec = (top == '0) ? SPW'(STACK_DEPTH - 1) : top - SPW'(1);

    always_comb begin
        pc_next = pc_in;
        push    = 1'b0;
        pop     = 1'b0;
        set_unf = 1'b0;
        if (call) begin
            push    = 1'b1;
            pc_next = in;
        end else if (ret) begin
            if (!empty) begin
                pop     = 1'b1;
                pc_next = stack[top_dec];
            end else begin
                set_unf = 1'b1;
            end
        end else if (d_we && d_op == PC_IDX) begin
            pc_next = in;
        end
    end

    // Pushing into a full stack overwrites the oldest slot, which is the one at top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= W'(RESET_PC);
            top   <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (!stall) begin
            pc <= pc_next;
            if (push) begin
                stack[top] <= pc_in;
                top        <= top_inc;
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    depth <= depth + DW'(1);
                end
            end else if (pop) begin
                top   <= top_dec;
                depth <= depth - DW'(1);
            end
            if (set_unf) begin
                unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NGEN; i++) begin
                regs[i] <= '0;
            end
        end else if (gen_wr) begin
            regs[d_op] <= in;
        end
    end

    // The synchroniser ignores stall so GPI keeps tracking the pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpi_meta <= '0;
            gpi_sync <= '0;
        end else begin
            gpi_meta <= gpi;
            gpi_sync <= gpi_meta;
        end
    end

    assign sel[0] = rx_op;
    assign sel[1] = ry_op;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = '0;
            if (sel[p] == PC_IDX) begin
                rd[p] = pc;
            end else if (sel[p] == ZERO_IDX) begin
                rd[p] = '0;
            end else if (sel[p] == GPI_IDX) begin
                rd[p] = gpi_sync;
            end else if (wr_en && d_op == sel[p]) begin
                rd[p] = in;
            end else begin
                rd[p] = regs[sel[p]];
            end
        end
    end

    assign rx_out    = rd[0];
    assign ry_out    = rd[1];
    assign gpo       = regs[GPO_IDX];
    assign pc_out    = pc;
    assign stack_ovf = ovf;
    assign stack_unf = unf;

endmodule
